// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - ALUFun operation codes (6-bit)
//   - operation group encoding taken from ALUFun[5:4]
//   - is_legal(): true for any ALUFun value the ALU implements
package alu_pkg;

    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b011000;
    localparam logic [5:0] OR    = 6'b011110;
    localparam logic [5:0] XOR   = 6'b010110;
    localparam logic [5:0] NOR   = 6'b010001;
    localparam logic [5:0] PASSA = 6'b011010;
    localparam logic [5:0] SLL   = 6'b100000;
    localparam logic [5:0] SRL   = 6'b100001;
    localparam logic [5:0] SRA   = 6'b100011;
    localparam logic [5:0] EQ    = 6'b110011;
    localparam logic [5:0] NEQ   = 6'b110001;
    localparam logic [5:0] LT    = 6'b110101;
    localparam logic [5:0] LEZ   = 6'b111101;
    localparam logic [5:0] LTZ   = 6'b111011;
    localparam logic [5:0] GTZ   = 6'b111111;

    typedef enum logic [1:0] {
        GRP_ADD   = 2'b00,
        GRP_LOGIC = 2'b01,
        GRP_SHIFT = 2'b10,
        GRP_CMP   = 2'b11
    } grp_e;

    function automatic logic is_legal(input logic [5:0] fun);
        case (fun)
            ADD, SUB,
            AND, OR, XOR, NOR, PASSA,
            SLL, SRL, SRA,
            EQ, NEQ, LT, LEZ, LTZ, GTZ: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: generic valid/ready register slice.
//   clk, reset      clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data payload
// The slice loads whenever it is empty or its content is being taken,
// so a held entry is never overwritten. in_ready is combinational from
// out_ready (no skid buffer).
module alu_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   clk, reset          clock, asynchronous active-low reset
//   in_valid/in_ready   operation handshake
//   ALUFun, Sign, A, B  operation code, signed mode, operands
//                       (A[SHW-1:0] = shift amount, B = shifted value)
//   out_valid/out_ready result handshake
//   S, Z, V, N, err     result, zero, overflow, negative, illegal-code
// Stage 1 registers the operands together with the add/sub sum and the
// decoded group; stage 2 selects the group result and registers S/flags.
// WIDTH must be >= 8 and a power of two.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       ALUFun,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             err
);

    typedef struct packed {
        logic [5:0]       fun;
        logic             sign;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   sum;
        grp_e             grp;
        logic             legal;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             z;
        logic             v;
        logic             n;
        logic             err;
    } s2_t;

    s1_t  s1_in, s1_q;
    s2_t  s2_in, s2_q;
    logic s1_valid;
    logic s2_ready;

    // ---------------- stage 1 input ----------------
    logic [WIDTH-1:0] b_in_eff;

    assign b_in_eff = ALUFun[0] ? ~B : B;

    always_comb begin
        s1_in.fun   = ALUFun;
        s1_in.sign  = Sign;
        s1_in.a     = A;
        s1_in.b     = B;
        s1_in.sum   = {1'b0, A} + {1'b0, b_in_eff} + {{WIDTH{1'b0}}, ALUFun[0]};
        s1_in.grp   = grp_e'(ALUFun[5:4]);
        s1_in.legal = is_legal(ALUFun);
    end

    alu_pipe_stage #(.DW($bits(s1_t))) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    // ---------------- stage 2 result select ----------------
    logic [WIDTH-1:0] a_q, b_q, b_eff_q, sum_q;
    logic             carry_q, is_sub;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             cond, ovf, neg, bad;

    assign a_q     = s1_q.a;
    assign b_q     = s1_q.b;
    assign is_sub  = s1_q.fun[0];
    assign b_eff_q = is_sub ? ~b_q : b_q;
    assign sum_q   = s1_q.sum[WIDTH-1:0];
    assign carry_q = s1_q.sum[WIDTH];
    assign shamt   = a_q[SHW-1:0];

    always_comb begin
        res  = '0;
        cond = 1'b0;
        ovf  = 1'b0;
        neg  = 1'b0;
        bad  = 1'b0;

        case (s1_q.grp)
            GRP_ADD: begin
                res = sum_q;
                if (s1_q.sign) begin
                    // Signed overflow: both addends agree in sign but the sum does not.
                    ovf = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
                    neg = sum_q[WIDTH-1];
                end else begin
                    // For SUB the carry-out of A + ~B + 1 is the inverted borrow.
                    ovf = is_sub ? !carry_q : carry_q;
                    neg = is_sub && !carry_q;
                end
            end
            GRP_LOGIC: begin
                case (s1_q.fun)
                    AND:     res = a_q & b_q;
                    OR:      res = a_q | b_q;
                    XOR:     res = a_q ^ b_q;
                    NOR:     res = ~(a_q | b_q);
                    PASSA:   res = a_q;
                    default: res = '0;
                endcase
            end
            GRP_SHIFT: begin
                case (s1_q.fun)
                    SLL:     res = b_q << shamt;
                    SRL:     res = b_q >> shamt;
                    SRA:     res = $signed(b_q) >>> shamt;
                    default: res = '0;
                endcase
            end
            GRP_CMP: begin
                case (s1_q.fun)
                    EQ:      cond = (a_q == b_q);
                    NEQ:     cond = (a_q != b_q);
                    LT:      cond = s1_q.sign ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
                    LEZ:     cond = a_q[WIDTH-1] || (a_q == '0);
                    LTZ:     cond = a_q[WIDTH-1];
                    GTZ:     cond = !a_q[WIDTH-1] && (a_q != '0);
                    default: cond = 1'b0;
                endcase
                res = {{(WIDTH-1){1'b0}}, cond};
            end
            default: res = '0;
        endcase

        // Illegal codes override whatever the group produced.
        if (!s1_q.legal) begin
            res = '0;
            ovf = 1'b0;
            neg = 1'b0;
            bad = 1'b1;
        end

        s2_in.s   = res;
        s2_in.z   = (res == '0);
        s2_in.v   = ovf;
        s2_in.n   = neg;
        s2_in.err = bad;
    end

    alu_pipe_stage #(.DW($bits(s2_t))) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign S   = s2_q.s;
    assign Z   = s2_q.z;
    assign V   = s2_q.v;
    assign N   = s2_q.n;
    assign err = s2_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32 and WIDTH=16 instances).
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_valid16 = 1'b0;
    logic        in_ready, in_ready16;
    logic [5:0]  ALUFun = '0;
    logic        Sign = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        out_valid, out_valid16;
    logic        out_ready = 1'b1, ordy16 = 1'b1;
    logic [31:0] S;
    logic [15:0] S16;
    logic        Z, V, N, err, Z16, V16, N16, err16;

    exp_t q32[$];
    exp_t q16[$];
    int   total = 0;
    int   bad = 0;
    int   occ = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUFun(ALUFun), .Sign(Sign), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Z(Z), .V(V), .N(N), .err(err)
    );

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .ALUFun(ALUFun), .Sign(Sign), .A(A[15:0]), .B(B[15:0]),
        .out_valid(out_valid16), .out_ready(ordy16),
        .S(S16), .Z(Z16), .V(V16), .N(N16), .err(err16)
    );

    task automatic check(input string nm, input logic [39:0] got, input logic [39:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on w-bit values.
    function automatic exp_t model(input logic [5:0] op, input logic sg,
                                   input logic [31:0] ai, input logic [31:0] bi, input int w);
        exp_t r;
        longint unsigned mask, a, b, u;
        longint sa, sb, d, mx, mn;
        int amt;
        mask = (64'd1 << w) - 64'd1;
        a = {32'd0, ai} & mask;
        b = {32'd0, bi} & mask;
        sa = longint'(a);
        sb = longint'(b);
        if (a >= (64'd1 << (w - 1))) sa = sa - longint'(64'd1 << w);
        if (b >= (64'd1 << (w - 1))) sb = sb - longint'(64'd1 << w);
        mx = longint'((64'd1 << (w - 1)) - 64'd1);
        mn = -mx - 1;
        amt = int'(a % 64'(w));
        r = '{32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        u = 0;
        case (op)
            ADD: begin
                u = (a + b) & mask;
                d = sa + sb;
                r.v = sg ? (d > mx || d < mn) : ((a + b) > mask);
                r.n = sg ? u[w-1] : 1'b0;
            end
            SUB: begin
                u = (a - b) & mask;
                d = sa - sb;
                r.v = sg ? (d > mx || d < mn) : (a < b);
                r.n = sg ? u[w-1] : (a < b);
            end
            AND:     u = a & b;
            OR:      u = a | b;
            XOR:     u = a ^ b;
            NOR:     u = ~(a | b) & mask;
            PASSA:   u = a;
            SLL:     u = (b << amt) & mask;
            SRL:     u = b >> amt;
            SRA:     u = longint'(sb >>> amt) & mask;
            EQ:      u = 64'(a == b);
            NEQ:     u = 64'(a != b);
            LT:      u = sg ? 64'(sa < sb) : 64'(a < b);
            LEZ:     u = 64'(sa <= 0);
            LTZ:     u = 64'(sa < 0);
            GTZ:     u = 64'(sa > 0);
            default: r.e = 1'b1;
        endcase
        r.s = u[31:0];
        r.z = (u == 0);
        return r;
    endfunction

    // Offer one op until accepted; push its expected result on acceptance.
    // mode: 0 = out_ready low, 1 = high, 2 = random.
    task automatic send(input logic [5:0] op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int mode, input bit w16, input exp_t ex);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            ALUFun = op; Sign = sg; A = a; B = b;
            in_valid   = !w16;
            in_valid16 = w16;
            out_ready  = (mode == 2) ? ($urandom_range(3) != 0) : (mode == 1);
            #2;
            if (w16 ? in_ready16 : in_ready) begin
                if (w16) q16.push_back(ex);
                else     q32.push_back(ex);
                done = 1;
            end else if (++n > 60) begin
                total++; bad++;
                $display("FAIL accept_timeout: in_ready stayed 0 for op %b", op);
                done = 1;
            end
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int mode, input bit w16);
        send(op, sg, a, b, mode, w16, model(op, sg, a, b, w16 ? 16 : 32));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            in_valid = 0; in_valid16 = 0; out_ready = 1;
            n++;
        end
        @(negedge clk);
        in_valid = 0; in_valid16 = 0; out_ready = 1;
        if (q32.size() != 0 || q16.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending32=%0d pending16=%0d", q32.size(), q16.size());
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return $urandom_range(40);
            default: return $urandom;
        endcase
    endfunction

    // Monitor for the 32-bit instance: result scoreboard, stall stability, in_ready.
    initial begin
        exp_t        e;
        logic [36:0] held;
        bit          hold_ok;
        held = '0;
        hold_ok = 0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                hold_ok = 0;
            end else begin
                check("in_ready", in_ready, !(occ == 2 && !out_ready));
                if (hold_ok) check("stall_hold", {out_valid, S, Z, V, N, err}, held);
                if (out_valid && out_ready) begin
                    if (q32.size() == 0) begin
                        total++; bad++;
                        $display("FAIL res32: unexpected output S=%h, none expected", S);
                    end else begin
                        e = q32.pop_front();
                        check("res32", {S, Z, V, N, err}, {e.s, e.z, e.v, e.n, e.e});
                    end
                end
                occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
                hold_ok = out_valid && !out_ready;
                held = {1'b1, S, Z, V, N, err};
            end
        end
    end

    // Monitor for the 16-bit instance (always ready).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (reset && out_valid16) begin
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL res16: unexpected output S=%h, none expected", S16);
                end else begin
                    e = q16.pop_front();
                    check("res16", {16'd0, S16, Z16, V16, N16, err16}, {e.s, e.z, e.v, e.n, e.e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        logic [5:0] legal_ops [16];
        logic [5:0] op;
        legal_ops = '{ADD, SUB, AND, OR, XOR, NOR, PASSA, SLL, SRL, SRA,
                      EQ, NEQ, LT, LEZ, LTZ, GTZ};

        // Reset state
        #1;
        check("reset_state", {out_valid, S, Z, V, N, err}, 37'd0);
        check("reset_state16", {out_valid16, S16, Z16, V16, N16, err16}, 21'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vectors with hand-derived expectations
        send(ADD, 1, 32'h7FFFFFFF, 32'h1, 1, 0, '{32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0});
        send(SUB, 0, 32'h1, 32'h2, 1, 0, '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        send(SRA, 0, 32'd4, 32'h80000000, 1, 0, '{32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0});
        send(SLL, 0, 32'd33, 32'h1, 1, 0, '{32'h2, 1'b0, 1'b0, 1'b0, 1'b0});
        send(NOR, 0, 32'h0, 32'h0, 1, 0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
        send(LT, 1, 32'hFFFFFFFF, 32'h1, 1, 0, '{32'h1, 1'b0, 1'b0, 1'b0, 1'b0});
        send(LT, 0, 32'hFFFFFFFF, 32'h1, 1, 0, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        send(GTZ, 1, 32'h0, 32'h5, 1, 0, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
        send(6'b000010, 1, 32'h5, 32'h3, 1, 0, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        send(ADD, 1, 32'h7FFF, 32'h1, 1, 1, '{32'h8000, 1'b0, 1'b1, 1'b1, 1'b0});
        send(SUB, 0, 32'h1, 32'h2, 1, 1, '{32'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        drain();

        // Reset mid-stream: fill both stages under backpressure, then reset
        issue(ADD, 0, 32'd10, 32'd20, 0, 0);
        issue(SUB, 0, 32'd9, 32'd2, 0, 0);
        @(negedge clk);
        in_valid = 0;
        #1;
        reset = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_s", S, 32'd0);
        q32.delete();
        occ = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(ADD, 0, 32'd3, 32'd4, 1, 0);
        @(negedge clk);
        in_valid = 0;
        #1;
        check("lat_edge1", out_valid, 1'b0);
        @(negedge clk);
        #1;
        check("lat_edge2", out_valid, 1'b1);
        drain();

        // Backpressure: 5 ADDs back to back, out_ready low in cycles 3..5
        i = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            if (i < 5) begin
                ALUFun = ADD; Sign = 0; A = i; B = i;
                in_valid = 1;
                #2;
                if (in_ready) begin
                    q32.push_back('{32'(2 * i), (i == 0), 1'b0, 1'b0, 1'b0});
                    i++;
                end
            end else begin
                in_valid = 0;
            end
            if (c == 4) check("bp_in_ready_low", in_ready, 1'b0);
        end
        check("bp_all_sent", i, 5);
        drain();

        // Randomized traffic on both widths
        for (int k = 0; k < 400; k++) begin
            bit w16;
            if ($urandom_range(6) == 0) op = 6'($urandom);
            else                        op = legal_ops[$urandom_range(15)];
            w16 = ($urandom_range(7) == 0);
            issue(op, 1'($urandom), rnd_opnd(), rnd_opnd(), 2, w16);
            if ($urandom_range(4) == 0) begin
                @(negedge clk);
                in_valid = 0; in_valid16 = 0;
                out_ready = ($urandom_range(3) != 0);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
